mp_vertical_max: RTL and testbench

Second-row stage of the 2×2 max-pool path. Consumes one buffered first-row segment from the max-pool row buffer controller (its read side) and the matching second-row word stream. Emits the lane-wise vertical maximum of each word pair on a valid/ready output. Sits directly downstream of the row buffer and upstream of the pooled-feature-map writer.

---
 rtl/mp_vertical_max.sv | 138 +++++++++++++
 tb/tb_mp_vertical_max.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_vertical_max.sv
// Second-row stage of the 2x2 max-pool: lane-wise max of a buffered first-row word and the
// matching second-row word, queued in a 2-entry output FIFO. Define MP_VMAX_SIGNED_EN for signed lanes.
module mp_vertical_max #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        ifm_width,
    input  logic              buf_full,
    output logic              buf_rd,
    input  logic [DATA_W-1:0] buf_data,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              seg_done
);

    localparam int unsigned NumLanes = DATA_W / LANE_W;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StWaitLow = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  seg_len_q, seg_len_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] s_hold_q;
    logic              seg_done_q;

    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        occ_q, occ_d;

    logic              pop, push, fire, last_fire, credit_ok;
    logic [2:0]        occ_after;
    logic [DATA_W-1:0] max_word;

    assign pop  = m_valid & m_ready;
    assign push = rd_pend_q;

    // Count the in-flight read so the FIFO can always absorb the result a cycle later.
    assign occ_after = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign credit_ok = occ_after < 3'd2;

    assign fire      = (state_q == StRun) & s_valid & buf_full & credit_ok;
    assign last_fire = fire & (rd_cnt_q == seg_len_q - CNT_W'(1));

    assign s_ready  = fire;
    assign buf_rd   = fire;
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = fifo_q[rd_ptr_q];
    assign seg_done = seg_done_q;

    for (genvar i = 0; i < NumLanes; i++) begin : g_lane
        logic [LANE_W-1:0] hold_lane, buf_lane;
        logic              hold_gt;
        assign hold_lane = s_hold_q[i*LANE_W +: LANE_W];
        assign buf_lane  = buf_data[i*LANE_W +: LANE_W];
`ifdef MP_VMAX_SIGNED_EN
        assign hold_gt = $signed(hold_lane) > $signed(buf_lane);
`else
        assign hold_gt = hold_lane > buf_lane;
`endif
        assign max_word[i*LANE_W +: LANE_W] = hold_gt ? hold_lane : buf_lane;
    end

    always_comb begin
        state_d   = state_q;
        seg_len_d = seg_len_q;
        rd_cnt_d  = rd_cnt_q;
        case (state_q)
            StIdle: begin
                if (buf_full) begin
                    state_d   = StRun;
                    seg_len_d = (ifm_width == 9'd26) ? CNT_W'(6) : CNT_W'(13);
                    rd_cnt_d  = '0;
                end
            end
            StRun: begin
                if (last_fire) begin
                    state_d  = StWaitLow;
                    rd_cnt_d = '0;
                end else if (fire) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            StWaitLow: begin
                if (!buf_full) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (!push && pop) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            seg_len_q  <= CNT_W'(13);
            rd_cnt_q   <= '0;
            rd_pend_q  <= 1'b0;
            s_hold_q   <= '0;
            seg_done_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            seg_len_q  <= seg_len_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_pend_q  <= fire;
            seg_done_q <= last_fire;
            occ_q      <= occ_d;
            if (fire) s_hold_q <= s_data;
            // buf_data is only valid in the cycle right after the read strobe.
            if (push) begin
                fifo_q[wr_ptr_q] <= max_word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_mp_vertical_max.sv
// Randomized bench for mp_vertical_max: models the row buffer and the stream source, and checks
// the pooled output against a lane-wise max reference built from the same word arrays.
module tb_mp_vertical_max;

    logic        clk;
    logic        rst;
    logic [8:0]  ifm_width;
    logic        buf_full;
    logic        buf_rd;
    logic [31:0] buf_data;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        seg_done;

    mp_vertical_max #(
        .DATA_W(32),
        .LANE_W(8),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ifm_width(ifm_width),
        .buf_full (buf_full),
        .buf_rd   (buf_rd),
        .buf_data (buf_data),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .seg_done (seg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] buf_all [0:1023];
    logic [31:0] str_all [0:1023];
    logic [31:0] exp_q [$];
    logic [31:0] out_log [$];

    int          idx = 0;
    int          seg_start = 0;
    int          seg_end = 0;
    int          n_fire = 0;
    int          n_done = 0;
    int          n_seg_model = 0;
    int          n_cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          lat_t = 0;
    int unsigned v_pct = 100;
    int unsigned r_pct = 100;
    bit          last_prev = 0;
    bit          drop_pend = 0;
    bit          hold_prev = 0;
    logic [31:0] hold_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each 8-bit lane independently takes the larger value.
    function automatic logic [31:0] lane_max(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) begin
            int x, y;
`ifdef MP_VMAX_SIGNED_EN
            x = $signed(a[l*8 +: 8]);
            y = $signed(b[l*8 +: 8]);
`else
            x = int'(a[l*8 +: 8]);
            y = int'(b[l*8 +: 8]);
`endif
            r[l*8 +: 8] = (x > y) ? x[7:0] : y[7:0];
        end
        return r;
    endfunction

    // One clock: sample at negedge, update buffer/stream models just after posedge.
    task automatic cycle();
        logic fire, last;
        @(negedge clk);
        n_cyc++;
        check("rdy_eq_rd", 64'(s_ready), 64'(buf_rd));
        if (lat_t == 2) begin
            check("lat_early", 64'(m_valid), 64'd0);
            lat_t = 1;
        end else if (lat_t == 1) begin
            check("lat_f2", 64'(m_valid), 64'd1);
            lat_t = 0;
        end
        check("seg_done", 64'(seg_done), 64'(last_prev));
        if (seg_done) n_done++;
        if (hold_prev) check("hold", 64'({m_valid, m_data}), 64'({1'b1, hold_data}));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(m_valid), 64'd0);
            end else begin
                check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
            end
            out_log.push_back(m_data);
        end
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;
        fire = buf_rd;
        last = 1'b0;
        if (fire) begin
            check("rd_ok", 64'((idx < seg_end) && buf_full && s_valid), 64'd1);
            if (exp_q.size() == 0 && lat_t == 0) lat_t = 2;
            exp_q.push_back(lane_max(buf_all[idx], str_all[idx]));
            last = (idx == seg_end - 1);
            if (idx == seg_start) first_cyc = n_cyc;
            if (last) last_cyc = n_cyc;
            n_fire++;
        end
        @(posedge clk);
        #1;
        if (fire) begin
            buf_data = buf_all[idx];
            idx++;
        end else begin
            buf_data = $urandom;
        end
        last_prev = last;
        if (last) begin
            drop_pend = 1'b1;
        end else if (drop_pend) begin
            buf_full  = 1'b0;
            drop_pend = 1'b0;
        end
        s_valid = ($urandom_range(99) < v_pct);
        s_data  = s_valid ? str_all[idx] : $urandom;
        m_ready = ($urandom_range(99) < r_pct);
    endtask

    task automatic load_segment(input int width, input int kind);
        int n;
        n = (width == 26) ? 6 : 13;
        seg_start = idx;
        seg_end   = idx + n;
        for (int k = 0; k < n; k++) begin
            case (kind)
                1: begin
                    buf_all[idx+k] = 32'h01020304 + 32'(k);
                    str_all[idx+k] = 32'h04030201;
                end
                2: begin
                    buf_all[idx+k] = 32'h80FF7F01;
                    str_all[idx+k] = 32'h01010101;
                end
                default: begin
                    buf_all[idx+k] = $urandom;
                    str_all[idx+k] = $urandom;
                end
            endcase
        end
        ifm_width = 9'(width);
        buf_full  = 1'b1;
        s_valid   = ($urandom_range(99) < v_pct);
        s_data    = s_valid ? str_all[idx] : $urandom;
        m_ready   = ($urandom_range(99) < r_pct);
    endtask

    task automatic run_segment(input int width, input int kind, input int unsigned vp,
                               input int unsigned rp, input bit glitch, input int stall);
        int c, f0, g_state, g_left;
        v_pct = vp;
        r_pct = rp;
        f0 = n_fire;
        g_state = 0;
        g_left = 0;
        load_segment(width, kind);
        if (stall > 0) m_ready = 1'b0;
        c = 0;
        while (!(idx == seg_end && !buf_full) && c < 400) begin
            cycle();
            c++;
            if (c == 1) ifm_width = (width == 26) ? 9'd13 : 9'd26;
            if (c < stall) m_ready = 1'b0;
            if (stall > 0 && c == stall) check("bp_fires", 64'(n_fire - f0), 64'd2);
            if (glitch) begin
                if (g_state == 0 && idx >= seg_start + 4) begin
                    buf_full = 1'b0;
                    g_state = 1;
                    g_left = 3;
                end else if (g_state == 1) begin
                    g_left--;
                    if (g_left == 0) begin
                        buf_full = 1'b1;
                        g_state = 2;
                    end
                end
            end
        end
        if (c >= 400) check("seg_timeout", 64'd1, 64'd0);
        else n_seg_model++;
        repeat (2) cycle();
    endtask

    task automatic drain();
        int c;
        v_pct = 0;
        r_pct = 100;
        s_valid = 1'b0;
        m_ready = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            cycle();
            c++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base, d0, f0;
        for (int i = 0; i < 1024; i++) begin
            buf_all[i] = $urandom;
            str_all[i] = $urandom;
        end
        rst = 1'b1;
        ifm_width = 9'd13;
        buf_full = 1'b0;
        buf_data = '0;
        s_valid = 1'b1;
        s_data = str_all[0];
        m_ready = 1'b1;

        @(negedge clk);
        check("rst_buf_rd", 64'(buf_rd), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_seg_done", 64'(seg_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle();

        // Directed 13-word segment at full throughput.
        base = out_log.size();
        run_segment(13, 1, 100, 100, 1'b0, 0);
        drain();
        check("t13_w0", 64'(out_log[base]), 64'h04030304);
        check("t13_w12", 64'(out_log[base+12]), 64'h04030310);
        check("t13_thru", 64'(last_cyc - first_cyc), 64'd12);

        // Width 26 gives 6-pair segments.
        for (int s = 0; s < 2; s++) begin
            f0 = n_fire;
            run_segment(26, 0, 100, 100, 1'b0, 0);
            check("w26_fires", 64'(n_fire - f0), 64'd6);
        end

        // Backpressure: 5 stalled cycles from segment start.
        base = out_log.size();
        run_segment(13, 0, 100, 100, 1'b0, 5);
        drain();
        check("bp_count", 64'(out_log.size() - base), 64'd13);

        // Lane signedness.
        base = out_log.size();
        run_segment(13, 2, 100, 100, 1'b0, 0);
        drain();
`ifdef MP_VMAX_SIGNED_EN
        check("sign_word", 64'(out_log[base]), 64'h01017F01);
`else
        check("sign_word", 64'(out_log[base]), 64'h80FF7F01);
`endif

        // buf_full dropping mid-segment pauses firing without restarting the count.
        f0 = n_fire;
        run_segment(13, 0, 100, 100, 1'b1, 0);
        check("glitch_fires", 64'(n_fire - f0), 64'd13);

        // Random gaps and backpressure over 4 segments.
        d0 = n_done;
        for (int s = 0; s < 4; s++) begin
            run_segment(($urandom_range(1) == 1) ? 26 : 13, 0, 50, 50, 1'b0, 0);
        end
        drain();
        check("rand_seg_done", 64'(n_done - d0), 64'd4);

        // Reset mid-segment with a full FIFO.
        v_pct = 100;
        r_pct = 0;
        load_segment(13, 0);
        m_ready = 1'b0;
        repeat (6) cycle();
        check("pre_rst_valid", 64'(m_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_m_valid", 64'(m_valid), 64'd0);
        check("rst_mid_buf_rd", 64'(buf_rd), 64'd0);
        check("rst_mid_s_ready", 64'(s_ready), 64'd0);
        exp_q.delete();
        last_prev = 1'b0;
        drop_pend = 1'b0;
        hold_prev = 1'b0;
        lat_t = 0;
        idx = seg_end;
        @(posedge clk);
        #1;
        rst = 1'b0;
        buf_full = 1'b0;
        s_valid = 1'b1;
        s_data = str_all[idx];
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_m_valid", 64'(m_valid), 64'd0);
            check("post_rst_buf_rd", 64'(buf_rd), 64'd0);
            @(posedge clk);
            #1;
        end
        f0 = n_fire;
        run_segment(13, 0, 100, 100, 1'b0, 0);
        check("recover_fires", 64'(n_fire - f0), 64'd13);

        drain();
        check("seg_done_total", 64'(n_done), 64'(n_seg_model));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
